// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator sharing one prescaled period counter.
// Duty and top writes land in shadow registers and transfer at the period wrap.
module pwm_multi_channel #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [CHANNELS-1:0]   en_mask,
    input  logic                  invert,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start
);

    logic [PRESCALE_W-1:0] pcnt;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      top_sh;
    logic [WIDTH-1:0]      top_act;
    logic [WIDTH-1:0]      duty_sh  [CHANNELS];
    logic [WIDTH-1:0]      duty_act [CHANNELS];
    logic                  tick;
    logic                  wrap;
    logic [CHANNELS-1:0]   raw;
    logic [CHANNELS-1:0]   inv_vec;

    // >= rather than == so lowering prescale below pcnt ticks immediately.
    assign tick    = (pcnt >= prescale);
    assign wrap    = tick && (cnt == top_act);
    assign inv_vec = {CHANNELS{invert}};

    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (duty_act[i] > cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt         <= '0;
            cnt          <= '0;
            top_sh       <= '1;
            top_act      <= '1;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end

            // Active registers take the pre-edge shadow values; a write on
            // the wrap cycle therefore waits for the following wrap.
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap) begin
                    duty_act[i] <= duty_sh[i];
                end
                if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    duty_sh[i] <= wr_data;
                end
            end
            if (wrap) begin
                top_act <= top_sh;
            end
            if (wr_en && (wr_addr == ADDR_W'(CHANNELS))) begin
                top_sh <= wr_data;
            end

            pwm_out      <= (en_mask & (raw ^ inv_vec)) | (~en_mask & inv_vec);
            period_start <= wrap;
        end
    end

endmodule
